// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a small register bank, oversampled on the system clock.
// The top address is a read-only live status port; the rest are RW registers.
module spi_target_regs #(
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_cs,
  input  logic                   spi_sclk,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  input  logic [7:0]             status_in,
  output logic [8*(NREGS-1)-1:0] regs_out,
  output logic                   wr_pulse,
  output logic [AW-1:0]          wr_addr,
  output logic [7:0]             wr_data,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_cs_meta, r_cs_sync, r_cs_prev;
  logic          r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic          r_mosi_meta, r_mosi_sync;
  logic [2:0]    r_bitcnt;
  logic [6:0]    r_shift;
  logic [AW-1:0] r_addr;
  logic          r_wr;
  logic [7:0]    r_tx;
  logic          r_miso;
  logic          r_wr_pulse;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_regs [0:NREGS-2];

  logic          w_cs_fall, w_rise, w_fall, w_byte_done;
  logic [7:0]    w_rx;
  logic [AW-1:0] w_addr_inc, w_rd_addr;
  logic [7:0]    w_rd_val;
  logic [2:0]    w_tx_idx;

  // CS sync stages reset to "low" so a frame already in flight at reset release
  // produces no falling edge; only a fresh high->low on the pin starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta   <= 1'b0;
      r_cs_sync   <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_cs_meta   <= spi_cs;
      r_cs_sync   <= r_cs_meta;
      r_cs_prev   <= r_cs_sync;
      r_sclk_meta <= spi_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
  assign w_rise      = r_sclk_sync & ~r_sclk_prev;
  assign w_fall      = ~r_sclk_sync & r_sclk_prev;
  assign w_byte_done = w_rise & (r_bitcnt == 3'd7);
  assign w_rx        = {r_shift, r_mosi_sync};
  assign w_addr_inc  = r_addr + AW'(1);
  assign w_rd_addr   = (r_state == S_CMD) ? w_rx[AW-1:0] : w_addr_inc;
  assign w_tx_idx    = 3'd7 - r_bitcnt;

  always_comb begin
    w_rd_val = status_in;
    for (int unsigned k = 0; k < NREGS - 1; k++) begin
      if (w_rd_addr == AW'(k)) w_rd_val = r_regs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_cs_sync) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:   if (w_byte_done) w_state_nxt = S_DATA;
        S_DATA:  w_state_nxt = S_DATA;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int unsigned k = 0; k < NREGS - 1; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (r_cs_sync) begin
        r_miso <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_bitcnt <= '0;
              r_miso   <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= w_rx[6:0];
            end
            if (w_byte_done) begin
              r_wr   <= w_rx[7];
              r_addr <= w_rx[AW-1:0];
              r_tx   <= w_rd_val;
            end
          end
          S_DATA: begin
            if (w_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= w_rx[6:0];
            end
            if (w_byte_done) begin
              r_addr <= w_addr_inc;
              if (r_wr) begin
                if (r_addr != AW'(NREGS - 1)) begin
                  r_wr_pulse <= 1'b1;
                  r_wr_addr  <= r_addr;
                  r_wr_data  <= w_rx;
                end
                for (int unsigned k = 0; k < NREGS - 1; k++) begin
                  if (r_addr == AW'(k)) r_regs[k] <= w_rx;
                end
              end else begin
                r_tx <= w_rd_val;
              end
            end
            if (w_fall && !r_wr) r_miso <= r_tx[w_tx_idx];
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned k = 0; k < NREGS - 1; k++) regs_out[8*k +: 8] = r_regs[k];
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = (r_state != S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign wr_pulse    = r_wr_pulse;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: table of SPI frames with hand-computed
// results, plus abort and mid-frame reset sequences.
module tb_spi_target_regs;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [7:0]  status_in = 8'h00;
  logic [55:0] regs_out;
  logic        wr_pulse;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  spi_target_regs #(.NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .status_in  (status_in),
    .regs_out   (regs_out),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  n;
    logic [31:0] d;
    logic [7:0]  st;
    logic [31:0] erx;
    logic [3:0]  epul;
    logic [55:0] eregs;
    logic [2:0]  ewa;
    logic [7:0]  ewd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      clks(HALF);
      rx[7-i] = spi_miso;
      spi_sclk = 1'b1;
      clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_cs = 1'b0;
    clks(6);
  endtask

  task automatic spi_end();
    clks(HALF);
    spi_cs = 1'b1;
    clks(8);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [31:0] dv, ev;
    int          p0;

    vecs[0] = '{8'h82, 3'd1, 32'hA5000000, 8'h00, 32'h00000000, 4'd1, 56'h00_00_00_00_A5_00_00, 3'd2, 8'hA5};
    vecs[1] = '{8'h85, 3'd4, 32'h11223344, 8'h00, 32'h00000000, 4'd3, 56'h22_11_00_00_A5_00_44, 3'd0, 8'h44};
    vecs[2] = '{8'h05, 3'd3, 32'h00000000, 8'h3C, 32'h11223C00, 4'd0, 56'h22_11_00_00_A5_00_44, 3'd0, 8'h44};
    vecs[3] = '{8'h07, 3'd2, 32'hFFFF0000, 8'h9E, 32'h9E440000, 4'd0, 56'h22_11_00_00_A5_00_44, 3'd0, 8'h44};
    vecs[4] = '{8'h7A, 3'd1, 32'h00000000, 8'h00, 32'hA5000000, 4'd0, 56'h22_11_00_00_A5_00_44, 3'd0, 8'h44};
    vecs[5] = '{8'hF9, 3'd1, 32'h5A000000, 8'h00, 32'h00000000, 4'd1, 56'h22_11_00_00_A5_5A_44, 3'd1, 8'h5A};
    vecs[6] = '{8'h87, 3'd2, 32'hFF770000, 8'h00, 32'h00000000, 4'd1, 56'h22_11_00_00_A5_5A_77, 3'd0, 8'h77};

    clks(4);
    chk("rst_regs", 64'(regs_out), 64'h0);
    chk("rst_miso", 64'(spi_miso), 64'h0);
    chk("rst_oe", 64'(spi_miso_oe), 64'h0);
    chk("rst_pulse", 64'(wr_pulse), 64'h0);
    chk("rst_waddr", 64'(wr_addr), 64'h0);
    chk("rst_wdata", 64'(wr_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    clks(6);

    for (int v = 0; v < 7; v++) begin
      p0 = pulse_cnt;
      status_in = vecs[v].st;
      dv = vecs[v].d;
      ev = vecs[v].erx;
      spi_begin();
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'h1);
      chk($sformatf("v%0d_oe", v), 64'(spi_miso_oe), 64'h1);
      spi_bits(vecs[v].cmd, 8, rx);
      chk($sformatf("v%0d_cmd_miso", v), 64'(rx), 64'h0);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        spi_bits(dv[31-8*i -: 8], 8, rx);
        chk($sformatf("v%0d_rx%0d", v, i), 64'(rx), 64'(ev[31-8*i -: 8]));
      end
      spi_end();
      chk($sformatf("v%0d_pulses", v), 64'(pulse_cnt - p0), 64'(vecs[v].epul));
      chk($sformatf("v%0d_regs", v), 64'(regs_out), 64'(vecs[v].eregs));
      chk($sformatf("v%0d_waddr", v), 64'(wr_addr), 64'(vecs[v].ewa));
      chk($sformatf("v%0d_wdata", v), 64'(wr_data), 64'(vecs[v].ewd));
      chk($sformatf("v%0d_busy_end", v), 64'(busy), 64'h0);
      chk($sformatf("v%0d_miso_end", v), 64'(spi_miso), 64'h0);
    end

    // Abort after 5 data bits, then a full write to the same register.
    p0 = pulse_cnt;
    spi_begin();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    chk("abort_pulses", 64'(pulse_cnt - p0), 64'h0);
    chk("abort_regs", 64'(regs_out), 64'h22_11_00_00_A5_5A_77);
    chk("abort_busy", 64'(busy), 64'h0);
    p0 = pulse_cnt;
    spi_begin();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'h3E, 8, rx);
    spi_end();
    chk("post_abort_pulses", 64'(pulse_cnt - p0), 64'h1);
    chk("post_abort_regs", 64'(regs_out), 64'h22_11_00_00_A5_3E_77);
    chk("post_abort_waddr", 64'(wr_addr), 64'h1);

    // Reset asserted at data bit 4; rest of the frame must be ignored.
    spi_begin();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'hF0, 4, rx);
    rst_n = 1'b0;
    #1;
    chk("mrst_regs", 64'(regs_out), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_oe", 64'(spi_miso_oe), 64'h0);
    chk("mrst_miso", 64'(spi_miso), 64'h0);
    chk("mrst_pulse", 64'(wr_pulse), 64'h0);
    chk("mrst_waddr", 64'(wr_addr), 64'h0);
    chk("mrst_wdata", 64'(wr_data), 64'h0);
    clks(2);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    spi_bits(8'h0F, 4, rx);
    spi_bits(8'h99, 8, rx);
    chk("mrst_ignored_busy", 64'(busy), 64'h0);
    spi_end();
    chk("mrst_ignored_pulses", 64'(pulse_cnt - p0), 64'h0);
    chk("mrst_ignored_regs", 64'(regs_out), 64'h0);
    p0 = pulse_cnt;
    spi_begin();
    spi_bits(8'h84, 8, rx);
    spi_bits(8'hC3, 8, rx);
    spi_end();
    chk("mrst_next_pulses", 64'(pulse_cnt - p0), 64'h1);
    chk("mrst_next_regs", 64'(regs_out), 64'h00_00_C3_00_00_00_00);
    chk("mrst_next_waddr", 64'(wr_addr), 64'h4);
    chk("mrst_next_wdata", 64'(wr_data), 64'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
